// File: rtl/ip_dc_pkg.sv
// Shared definitions for the intra DC predictor: config field layout,
// controller states and accumulator sizing helpers.
package ip_dc_pkg;

  localparam int CONF_LOG2_LSB = 0;
  localparam int CONF_LOG2_W   = 3;
  localparam int CONF_FILT_BIT = 3;
  localparam int CONF_BASE_LSB = 4;

  localparam int LOG2_MAX_DEF = 5;
  localparam int PIX_W_DEF    = 8;
  localparam int MAX_S        = 1 << LOG2_MAX_DEF;
  localparam int SUM_W        = PIX_W_DEF + LOG2_MAX_DEF + 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DIV,
    OUT
  } dc_state_e;

  // Holds the sum of 2*S samples plus the S rounding term without overflow.
  function automatic int sum_width(input int pix_w, input int log2_max);
    return pix_w + log2_max + 1;
  endfunction

endpackage

// File: rtl/ip_get_dc_param_if.sv
// Config, reference-memory and prediction channels of the DC predictor.
// slave = predictor side, master = environment side.
interface ip_get_dc_param_if #(
  parameter int PIX_W  = 8,
  parameter int PPW    = 4,
  parameter int ADDR_W = 6,
  parameter int CONF_W = 4 + ADDR_W
);

  logic [CONF_W-1:0]      conf_in_rsc_dat;
  logic                   conf_in_rsc_vld;
  logic                   conf_in_rsc_rdy;
  logic [ADDR_W-1:0]      ref_top_adr;
  logic [PIX_W*PPW-1:0]   ref_top_q;
  logic [ADDR_W-1:0]      ref_left_adr;
  logic [PIX_W*PPW-1:0]   ref_left_q;
  logic [PIX_W*PPW-1:0]   pred_out_rsc_dat;
  logic                   pred_out_rsc_vld;
  logic                   pred_out_rsc_rdy;

  modport slave (
    input  conf_in_rsc_dat, conf_in_rsc_vld,
    output conf_in_rsc_rdy,
    output ref_top_adr, ref_left_adr,
    input  ref_top_q, ref_left_q,
    output pred_out_rsc_dat, pred_out_rsc_vld,
    input  pred_out_rsc_rdy
  );

  modport master (
    output conf_in_rsc_dat, conf_in_rsc_vld,
    input  conf_in_rsc_rdy,
    input  ref_top_adr, ref_left_adr,
    output ref_top_q, ref_left_q,
    input  pred_out_rsc_dat, pred_out_rsc_vld,
    output pred_out_rsc_rdy
  );

endinterface

// File: rtl/ip_dc_filter.sv
// One output sample of the DC predictor, with the HEVC edge smoothing
// applied on the first row / first column when enabled.
module ip_dc_filter
  import ip_dc_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] i_dc,
  input  logic [PIX_W-1:0] i_top_s,
  input  logic [PIX_W-1:0] i_left_s,
  input  logic             i_row0,
  input  logic             i_col0,
  input  logic             i_filt_en,
  output logic [PIX_W-1:0] o_pix
);

  localparam int EXT_W = PIX_W + 2;

  logic [EXT_W-1:0] w_dc_ext;
  logic [EXT_W-1:0] w_corner;
  logic [EXT_W-1:0] w_edge_top;
  logic [EXT_W-1:0] w_edge_left;

  // Two guard bits cover left + 2*dc + top + 2 at full sample range.
  assign w_dc_ext    = EXT_W'(i_dc);
  assign w_corner    = EXT_W'(i_left_s) + (w_dc_ext << 1) + EXT_W'(i_top_s) + EXT_W'(2);
  assign w_edge_top  = EXT_W'(i_top_s) + w_dc_ext * EXT_W'(3) + EXT_W'(2);
  assign w_edge_left = EXT_W'(i_left_s) + w_dc_ext * EXT_W'(3) + EXT_W'(2);

  always_comb begin
    o_pix = i_dc;
    if (i_filt_en) begin
      if (i_row0 && i_col0) begin
        o_pix = PIX_W'(w_corner >> 2);
      end else if (i_row0) begin
        o_pix = PIX_W'(w_edge_top >> 2);
      end else if (i_col0) begin
        o_pix = PIX_W'(w_edge_left >> 2);
      end
    end
  end

endmodule

// File: rtl/ip_get_dc_param.sv
// Intra DC predictor: reads top/left references, computes the rounded DC
// value and streams the (optionally edge-filtered) block row-major.
module ip_get_dc_param
  import ip_dc_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int PPW      = 4,
  parameter int LOG2_MAX = 5,
  parameter int ADDR_W   = 6,
  parameter int CONF_W   = 4 + ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  ip_get_dc_param_if.slave bus,
  output logic             err_o
);

  localparam int WORD_W    = PIX_W * PPW;
  localparam int LOG2_PPW  = $clog2(PPW);
  localparam int WIDX_W    = (LOG2_MAX > LOG2_PPW) ? LOG2_MAX - LOG2_PPW : 1;
  localparam int MAX_WORDS = 1 << WIDX_W;
  localparam int SUM_L     = sum_width(PIX_W, LOG2_MAX);

  dc_state_e r_state, w_state_next;

  logic                r_conf_rdy, r_err;
  logic [2:0]          r_log2;
  logic                r_filt;
  logic [WIDX_W-1:0]   r_n_m1, r_iss_idx, r_q_idx, r_xw;
  logic [LOG2_MAX-1:0] r_s_m1, r_y;
  logic                r_iss_vld, r_q_vld, r_all_loaded;
  logic [ADDR_W-1:0]   r_adr;
  logic [SUM_L-1:0]    r_sum, w_lane_sum;
  logic [PIX_W-1:0]    r_dc, w_dc, w_left_s;
  logic [WORD_W-1:0]   r_top  [MAX_WORDS];
  logic [WORD_W-1:0]   r_left [MAX_WORDS];
  logic [WORD_W-1:0]   r_pdat, w_word, w_top_word, w_left_word;
  logic                r_pvld;

  logic [2:0]          w_cfg_log2;
  logic                w_cfg_filt, w_cfg_legal, w_conf_fire;
  logic [ADDR_W-1:0]   w_cfg_base;
  logic [WIDX_W-1:0]   w_cfg_n_m1;
  logic [LOG2_MAX-1:0] w_cfg_s_m1;
  logic                w_last_cap, w_load, w_done, w_row0, w_col0_word;

  assign w_cfg_log2  = bus.conf_in_rsc_dat[CONF_LOG2_LSB +: CONF_LOG2_W];
  assign w_cfg_filt  = bus.conf_in_rsc_dat[CONF_FILT_BIT];
  assign w_cfg_base  = bus.conf_in_rsc_dat[CONF_BASE_LSB +: ADDR_W];
  assign w_cfg_legal = (int'(w_cfg_log2) >= 2) && (int'(w_cfg_log2) <= LOG2_MAX) &&
                       (int'(w_cfg_log2) >= LOG2_PPW);
  assign w_cfg_n_m1  = WIDX_W'((1 << (int'(w_cfg_log2) - LOG2_PPW)) - 1);
  assign w_cfg_s_m1  = LOG2_MAX'((1 << int'(w_cfg_log2)) - 1);
  assign w_conf_fire = r_conf_rdy && bus.conf_in_rsc_vld;

  assign w_last_cap = r_q_vld && (r_q_idx == r_n_m1);
  assign w_load     = (r_state == OUT) && !r_all_loaded && (!r_pvld || bus.pred_out_rsc_rdy);
  assign w_done     = (r_state == OUT) && r_all_loaded && r_pvld && bus.pred_out_rsc_rdy;

  // Rounded mean of the 2*S references: (sum + S) >> (log2_size + 1).
  assign w_dc = PIX_W'((r_sum + (SUM_L'(1) << r_log2)) >> ({1'b0, r_log2} + 4'd1));

  always_comb begin
    w_lane_sum = '0;
    for (int i = 0; i < PPW; i++) begin
      w_lane_sum = w_lane_sum + SUM_L'(bus.ref_top_q[i*PIX_W +: PIX_W])
                              + SUM_L'(bus.ref_left_q[i*PIX_W +: PIX_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (w_conf_fire && w_cfg_legal) w_state_next = READ;
      READ: if (w_last_cap) w_state_next = DIV;
      DIV:  w_state_next = OUT;
      OUT:  if (w_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_conf_rdy   <= 1'b0;
      r_err        <= 1'b0;
      r_log2       <= '0;
      r_filt       <= 1'b0;
      r_n_m1       <= '0;
      r_s_m1       <= '0;
      r_adr        <= '0;
      r_iss_vld    <= 1'b0;
      r_iss_idx    <= '0;
      r_q_vld      <= 1'b0;
      r_q_idx      <= '0;
      r_sum        <= '0;
      r_dc         <= '0;
      r_y          <= '0;
      r_xw         <= '0;
      r_all_loaded <= 1'b0;
      r_pvld       <= 1'b0;
      r_pdat       <= '0;
      for (int i = 0; i < MAX_WORDS; i++) begin
        r_top[i]  <= '0;
        r_left[i] <= '0;
      end
    end else begin
      r_err      <= 1'b0;
      r_conf_rdy <= (w_state_next == IDLE);
      // Memory read latency: address registered here, data valid one cycle later.
      r_q_vld    <= r_iss_vld;
      r_q_idx    <= r_iss_idx;

      if (w_conf_fire) begin
        r_err <= !w_cfg_legal;
        if (w_cfg_legal) begin
          r_log2    <= w_cfg_log2;
          r_filt    <= w_cfg_filt && (w_cfg_log2 < 3'd5);
          r_n_m1    <= w_cfg_n_m1;
          r_s_m1    <= w_cfg_s_m1;
          r_adr     <= w_cfg_base;
          r_iss_vld <= 1'b1;
          r_iss_idx <= '0;
          r_sum     <= '0;
        end
      end else if (r_iss_vld) begin
        if (r_iss_idx == r_n_m1) begin
          r_iss_vld <= 1'b0;
        end else begin
          r_iss_idx <= r_iss_idx + WIDX_W'(1);
          r_adr     <= r_adr + ADDR_W'(1);
        end
      end

      if (r_q_vld) begin
        r_top[r_q_idx]  <= bus.ref_top_q;
        r_left[r_q_idx] <= bus.ref_left_q;
        r_sum           <= r_sum + w_lane_sum;
      end

      if (r_state == DIV) begin
        r_dc         <= w_dc;
        r_y          <= '0;
        r_xw         <= '0;
        r_all_loaded <= 1'b0;
      end

      if (w_load) begin
        r_pdat <= w_word;
        r_pvld <= 1'b1;
        if (r_xw == r_n_m1) begin
          r_xw <= '0;
          if (r_y == r_s_m1) begin
            r_all_loaded <= 1'b1;
          end else begin
            r_y <= r_y + LOG2_MAX'(1);
          end
        end else begin
          r_xw <= r_xw + WIDX_W'(1);
        end
      end else if (r_pvld && bus.pred_out_rsc_rdy) begin
        r_pvld <= 1'b0;
      end
    end
  end

  assign w_top_word  = r_top[r_xw];
  assign w_left_word = r_left[r_y[LOG2_MAX-1 -: WIDX_W]];
  assign w_left_s    = w_left_word[int'(r_y[LOG2_PPW-1:0])*PIX_W +: PIX_W];
  assign w_row0      = (r_y == '0);
  assign w_col0_word = (r_xw == '0);

  generate
    for (genvar gi = 0; gi < PPW; gi++) begin : gen_lane
      ip_dc_filter #(.PIX_W(PIX_W)) u_filt (
        .i_dc      (r_dc),
        .i_top_s   (w_top_word[gi*PIX_W +: PIX_W]),
        .i_left_s  (w_left_s),
        .i_row0    (w_row0),
        .i_col0    ((gi == 0) ? w_col0_word : 1'b0),
        .i_filt_en (r_filt),
        .o_pix     (w_word[gi*PIX_W +: PIX_W])
      );
    end
  endgenerate

  assign bus.conf_in_rsc_rdy  = r_conf_rdy;
  assign bus.ref_top_adr      = r_adr;
  assign bus.ref_left_adr     = r_adr;
  assign bus.pred_out_rsc_dat = r_pdat;
  assign bus.pred_out_rsc_vld = r_pvld;
  assign err_o                = r_err;

endmodule
